// File: rtl/cmp_hyst_monitor_pkg.sv
// Shared types for the hysteretic compare monitor: FSM state encoding and compare-term bundle.
package cmp_hyst_monitor_pkg;

    typedef enum logic [1:0] {
        ST_LOW  = 2'd0,
        ST_RISE = 2'd1,
        ST_HIGH = 2'd2,
        ST_FALL = 2'd3
    } state_t;

    typedef struct packed {
        logic gt;
        logic lt;
        logic neg_raw;
    } cmp_terms_t;

endpackage

// File: rtl/cmp_thresh_stage.sv
// Constant-threshold compare stage: a > HI, a < LO and sign bit, all combinational.
module cmp_thresh_stage
    import cmp_hyst_monitor_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a,
    output cmp_terms_t   terms_c
);

    // Replicated patterns keep both compares against pure constants.
    localparam logic [W-1:0] HI = {W/2{2'b10}};
    localparam logic [W-1:0] LO = {W/2{2'b01}};

    always_comb begin
        terms_c         = '0;
        terms_c.gt      = (a > HI);
        terms_c.lt      = (a < LO);
        terms_c.neg_raw = a[W-1];
    end

endmodule

// File: rtl/cmp_hyst_monitor.sv
// Debounced hysteretic level monitor with rise/fall pulses and a saturating rise counter.
module cmp_hyst_monitor
    import cmp_hyst_monitor_pkg::*;
#(
    parameter int unsigned LUT_WIDTH = 4,
    parameter int unsigned DEBOUNCE  = 3,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    input  logic [LUT_WIDTH-1:0] a,
    output logic                 out_valid,
    output logic                 level,
    output logic                 rise,
    output logic                 fall,
    output logic                 neg,
    output logic [CNT_W-1:0]     evt_cnt
);

    localparam int unsigned DCNT_W = $clog2(DEBOUNCE + 1);

    cmp_terms_t        terms_c;
    state_t            state;
    state_t            state_nxt;
    logic [DCNT_W-1:0] dcnt;
    logic [DCNT_W-1:0] dcnt_nxt;
    logic [DCNT_W-1:0] dcnt_inc;
    logic              rise_nxt;
    logic              fall_nxt;
    logic [CNT_W-1:0]  evt_cnt_nxt;

    cmp_thresh_stage #(.W(LUT_WIDTH)) u_thresh (
        .a       (a),
        .terms_c (terms_c)
    );

    assign dcnt_inc = dcnt + DCNT_W'(1);

    // Next state, debounce count and event pulses for an accepted sample.
    always_comb begin
        state_nxt   = state;
        dcnt_nxt    = dcnt;
        rise_nxt    = 1'b0;
        fall_nxt    = 1'b0;
        evt_cnt_nxt = evt_cnt;
        if (in_valid) begin
            case (state)
                ST_LOW: begin
                    if (terms_c.gt) begin
                        if (DEBOUNCE == 1) begin
                            state_nxt = ST_HIGH;
                            rise_nxt  = 1'b1;
                        end else begin
                            state_nxt = ST_RISE;
                            dcnt_nxt  = DCNT_W'(1);
                        end
                    end
                end
                ST_RISE: begin
                    if (!terms_c.gt) begin
                        state_nxt = ST_LOW;
                        dcnt_nxt  = '0;
                    end else if (dcnt_inc == DCNT_W'(DEBOUNCE)) begin
                        state_nxt = ST_HIGH;
                        dcnt_nxt  = '0;
                        rise_nxt  = 1'b1;
                    end else begin
                        dcnt_nxt  = dcnt_inc;
                    end
                end
                ST_HIGH: begin
                    if (terms_c.lt) begin
                        if (DEBOUNCE == 1) begin
                            state_nxt = ST_LOW;
                            fall_nxt  = 1'b1;
                        end else begin
                            state_nxt = ST_FALL;
                            dcnt_nxt  = DCNT_W'(1);
                        end
                    end
                end
                ST_FALL: begin
                    if (!terms_c.lt) begin
                        state_nxt = ST_HIGH;
                        dcnt_nxt  = '0;
                    end else if (dcnt_inc == DCNT_W'(DEBOUNCE)) begin
                        state_nxt = ST_LOW;
                        dcnt_nxt  = '0;
                        fall_nxt  = 1'b1;
                    end else begin
                        dcnt_nxt  = dcnt_inc;
                    end
                end
                default: begin
                    state_nxt = ST_LOW;
                    dcnt_nxt  = '0;
                end
            endcase
        end
        if (rise_nxt && (evt_cnt != {CNT_W{1'b1}})) begin
            evt_cnt_nxt = evt_cnt + CNT_W'(1);
        end
    end

    // State and output registers; clear beats a coincident sample.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= ST_LOW;
            dcnt      <= '0;
            out_valid <= 1'b0;
            level     <= 1'b0;
            rise      <= 1'b0;
            fall      <= 1'b0;
            neg       <= 1'b0;
            evt_cnt   <= '0;
        end else if (clr) begin
            state     <= ST_LOW;
            dcnt      <= '0;
            out_valid <= 1'b0;
            level     <= 1'b0;
            rise      <= 1'b0;
            fall      <= 1'b0;
            evt_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            dcnt      <= dcnt_nxt;
            out_valid <= in_valid;
            level     <= (state_nxt == ST_HIGH) || (state_nxt == ST_FALL);
            rise      <= rise_nxt;
            fall      <= fall_nxt;
            evt_cnt   <= evt_cnt_nxt;
            if (in_valid) begin
                neg <= terms_c.neg_raw;
            end
        end
    end

endmodule
